keypad_matrix_scanner: RTL and testbench

// Input-side companion to the LED/14-segment output path on the Versa5G board.

---
 rtl/keypad_matrix_scanner_if.sv | 24 ++
 rtl/keypad_matrix_scanner.sv | 191 +++++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_matrix_scanner_if.sv
// Key-code delivery channel from the keypad scanner to its consumer:
// valid/ready code transfer plus release and drop event pulses.
interface keypad_matrix_scanner_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int CW = $clog2(ROWS * COLS);

  logic [CW-1:0] key_code;
  logic          key_valid;
  logic          key_ready;
  logic          key_release;
  logic          key_drop;

  modport master (
    output key_code, key_valid, key_release, key_drop,
    input  key_ready
  );

  modport slave (
    input  key_code, key_valid, key_release, key_drop,
    output key_ready
  );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// Scans a ROWS x COLS active-low push-button matrix, debounces, and emits one code per press.
// Define KEYPAD_REPEAT_EN to auto-repeat the held key every REPEAT_TICKS ticks.
module keypad_matrix_scanner #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 4096,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_TICKS = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ROWS-1:0]        row_n,
  output logic [COLS-1:0]        col_n,
  keypad_matrix_scanner_if.master key_if
);
  localparam int CW   = $clog2(ROWS * COLS);
  localparam int RW   = $clog2(ROWS);
  localparam int CLW  = $clog2(COLS);
  localparam int DIVW = $clog2(SCAN_DIV);
  localparam int DW   = $clog2(DEBOUNCE + 1);

  if (ROWS < 2 || COLS < 2 || SCAN_DIV < 2 || DEBOUNCE < 2 || REPEAT_TICKS < 1) begin : g_param_check
    $error("keypad_matrix_scanner: unsupported parameter set");
  end

  typedef enum logic [1:0] {S_SCAN, S_DEB, S_HELD} state_e;

  logic [ROWS-1:0] sync1_q, sync2_q, rows_low, lower_mask;
  logic [DIVW-1:0] div_q, div_d;
  logic            tick;
  state_e          state_q, state_d;
  logic [CLW-1:0]  col_q, col_d, col_next;
  logic [COLS-1:0] col_n_q;
  logic [RW-1:0]   cand_q, cand_d, low_idx;
  logic [DW-1:0]   cnt_q, cnt_d, rel_q, rel_d;
  logic            any_low, cand_ok, accept, hs, rpt_hit;
  logic [CW-1:0]   code_q, code_d, cand_code;
  logic            valid_q, valid_d, release_q, release_d, drop_q, drop_d;

  assign rows_low   = ~sync2_q;
  assign any_low    = |rows_low;
  assign tick       = (div_q == DIVW'(SCAN_DIV - 1));
  assign div_d      = tick ? '0 : div_q + 1'b1;
  assign col_next   = (col_q == CLW'(COLS - 1)) ? '0 : col_q + 1'b1;
  // The candidate only qualifies while no lower-index row is also low.
  assign lower_mask = (ROWS'(1) << cand_q) - ROWS'(1);
  assign cand_ok    = rows_low[cand_q] && !(|(rows_low & lower_mask));
  assign cand_code  = CW'(col_q) * CW'(ROWS) + CW'(cand_q);

  always_comb begin
    low_idx = '0;
    for (int unsigned i = ROWS; i > 0; i--) begin
      if (rows_low[i-1]) low_idx = RW'(i - 1);
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RPW = $clog2(REPEAT_TICKS + 1);
  logic [RPW-1:0] rpt_q, rpt_d, rpt_inc;

  always_comb begin
    rpt_d   = rpt_q;
    rpt_hit = 1'b0;
    rpt_inc = rpt_q + 1'b1;
    if (state_q != S_HELD) begin
      rpt_d = '0;
    end else if (tick && any_low) begin
      if (rpt_inc == RPW'(REPEAT_TICKS)) begin
        rpt_d   = '0;
        rpt_hit = 1'b1;
      end else begin
        rpt_d = rpt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rpt_q <= '0;
    else        rpt_q <= rpt_d;
  end
`else
  assign rpt_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    rel_d     = rel_q;
    accept    = 1'b0;
    release_d = 1'b0;
    if (tick) begin
      unique case (state_q)
        S_SCAN: begin
          if (any_low) begin
            cand_d  = low_idx;
            cnt_d   = DW'(1);
            state_d = S_DEB;
          end else begin
            col_d = col_next;
          end
        end
        S_DEB: begin
          if (cand_ok) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == DW'(DEBOUNCE)) begin
              accept  = 1'b1;
              cnt_d   = '0;
              rel_d   = '0;
              state_d = S_HELD;
            end
          end else begin
            cnt_d   = '0;
            col_d   = col_next;
            state_d = S_SCAN;
          end
        end
        S_HELD: begin
          if (any_low) begin
            rel_d  = '0;
            accept = rpt_hit;
          end else begin
            rel_d = rel_q + 1'b1;
            if (rel_d == DW'(DEBOUNCE)) begin
              release_d = 1'b1;
              rel_d     = '0;
              col_d     = col_next;
              state_d   = S_SCAN;
            end
          end
        end
        default: state_d = S_SCAN;
      endcase
    end
  end

  // A handshake in the accept cycle frees the slot, so the new code loads instead of dropping.
  always_comb begin
    hs      = valid_q & key_if.key_ready;
    code_d  = code_q;
    valid_d = valid_q & ~hs;
    drop_d  = 1'b0;
    if (accept) begin
      if (!valid_d) begin
        code_d  = cand_code;
        valid_d = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      div_q     <= '0;
      state_q   <= S_SCAN;
      col_q     <= '0;
      col_n_q   <= '1;
      cand_q    <= '0;
      cnt_q     <= '0;
      rel_q     <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      release_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      sync1_q   <= row_n;
      sync2_q   <= sync1_q;
      div_q     <= div_d;
      state_q   <= state_d;
      col_q     <= col_d;
      col_n_q   <= ~(COLS'(1) << col_d);
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      rel_q     <= rel_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      release_q <= release_d;
      drop_q    <= drop_d;
    end
  end

  assign col_n              = col_n_q;
  assign key_if.key_code    = code_q;
  assign key_if.key_valid   = valid_q;
  assign key_if.key_release = release_q;
  assign key_if.key_drop    = drop_q;
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed/randomized bench for keypad_matrix_scanner with a key-matrix model and
// timing expectations derived from the scan/debounce rules.
module tb_keypad_matrix_scanner;
  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 4, DEBOUNCE = 3, REPEAT_TICKS = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [ROWS-1:0] row_n;
  logic [COLS-1:0] col_n;
  logic [15:0]     keys = '0;
  int              cyc = 0;
  int              n_vec = 0;
  int              n_err = 0;

  keypad_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS)) kif ();

  keypad_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE), .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n), .key_if(kif)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_n = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (keys[c*ROWS + r] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic align();
    while (cyc % SCAN_DIV != 0) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    keys = '0;
    kif.key_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    cyc = 0;
  endtask

  function automatic logic [15:0] onehot(input int k);
    return 16'(1) << k;
  endfunction

  function automatic logic [3:0] drive(input int c);
    return ~(4'(1) << c);
  endfunction

  // Cycles from a slot start on column cur_col until key_valid shows a key in key_col.
  function automatic int latency(input int cur_col, input int key_col);
    return SCAN_DIV * (((key_col - cur_col + COLS) % COLS) + DEBOUNCE);
  endfunction

  task automatic press_check(input string tag, input logic [15:0] mask, input int exp_code,
                             input int s, input int hold);
    int e, r;
    logic seen;
    do_reset();
    wait_until(SCAN_DIV * s);
    keys = mask;
    e = cyc + latency(s % COLS, exp_code / ROWS);
    wait_until(e - 1);
    chk({tag, "_early"}, 32'(kif.key_valid), 0);
    step();
    chk({tag, "_valid"}, 32'(kif.key_valid), 1);
    chk({tag, "_code"}, 32'(kif.key_code), 32'(exp_code));
    chk({tag, "_nodrop"}, 32'(kif.key_drop), 0);
    repeat (hold) step();
    chk({tag, "_hold_valid"}, 32'(kif.key_valid), 1);
    chk({tag, "_hold_code"}, 32'(kif.key_code), 32'(exp_code));
    kif.key_ready = 1'b1;
    step();
    kif.key_ready = 1'b0;
    chk({tag, "_consumed"}, 32'(kif.key_valid), 0);
`ifndef KEYPAD_REPEAT_EN
    seen = 1'b0;
    repeat (40) begin
      step();
      seen |= kif.key_valid;
    end
    chk({tag, "_no_repeat"}, 32'(seen), 0);
`endif
    align();
    keys = '0;
    r = cyc + SCAN_DIV * DEBOUNCE;
    wait_until(r - 1);
    chk({tag, "_rel_early"}, 32'(kif.key_release), 0);
    step();
    chk({tag, "_release"}, 32'(kif.key_release), 1);
    step();
    chk({tag, "_rel_width"}, 32'(kif.key_release), 0);
  endtask

  task automatic quiet_window(input string tag);
    logic sv, sr, sd;
    sv = 1'b0; sr = 1'b0; sd = 1'b0;
    repeat (40) begin
      step();
      sv |= kif.key_valid;
      sr |= kif.key_release;
      sd |= kif.key_drop;
    end
    chk({tag, "_no_valid"}, 32'(sv), 0);
    chk({tag, "_no_release"}, 32'(sr), 0);
    chk({tag, "_no_drop"}, 32'(sd), 0);
  endtask

  initial begin
    int k, k3, c, r1, r2, s, e, r;
    kif.key_ready = 1'b0;

    // Reset values and free-running column scan.
    do_reset();
    rst_n = 1'b0;
    step();
    chk("rst_col_n", 32'(col_n), 32'hF);
    chk("rst_valid", 32'(kif.key_valid), 0);
    chk("rst_release", 32'(kif.key_release), 0);
    chk("rst_drop", 32'(kif.key_drop), 0);
    chk("rst_code", 32'(kif.key_code), 0);
    rst_n = 1'b1;
    cyc = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      chk("scan_col_n", 32'(col_n), 32'(drive((cyc / SCAN_DIV) % COLS)));
    end

    // Single presses: fixed col2/row1 first, then random keys and start slots.
    press_check("press9", onehot(9), 2*ROWS + 1, 1, 20);
    for (int i = 0; i < 4; i++) begin
      k = $urandom_range(0, 15);
      press_check("press_rand", onehot(k), k, $urandom_range(1, 4), $urandom_range(2, 16));
    end

    // Several rows low in one column: lowest row wins.
    press_check("multi_c1", onehot(1*ROWS + 0) | onehot(1*ROWS + 3), 1*ROWS + 0, 2, 4);
    c  = $urandom_range(0, 3);
    r1 = $urandom_range(0, 2);
    r2 = $urandom_range(r1 + 1, 3);
    press_check("multi_rand", onehot(c*ROWS + r1) | onehot(c*ROWS + r2), c*ROWS + r1, 3, 6);

    // One qualifying tick only: aborted press, column held during DEB then advanced.
    do_reset();
    c = $urandom_range(0, 3);
    k = c*ROWS + $urandom_range(0, 3);
    s = c + COLS;
    wait_until(SCAN_DIV * s);
    keys = onehot(k);
    wait_until(SCAN_DIV * s + SCAN_DIV);
    keys = '0;
    wait_until(SCAN_DIV * s + 2*SCAN_DIV - 1);
    chk("short_col_frozen", 32'(col_n), 32'(drive(c)));
    step();
    chk("short_col_adv", 32'(col_n), 32'(drive((c + 1) % COLS)));
    quiet_window("short");

    // Pending code 9, second key col0/row2 -> drop; then accept coinciding with handshake.
    do_reset();
    wait_until(SCAN_DIV);
    keys = onehot(9);
    e = cyc + latency(1, 2);
    wait_until(e);
    chk("drop_first_valid", 32'(kif.key_valid), 1);
    chk("drop_first_code", 32'(kif.key_code), 9);
    align();
    keys = '0;
    r = cyc + SCAN_DIV * DEBOUNCE;
    wait_until(r);
    chk("drop_rel1", 32'(kif.key_release), 1);
    keys = onehot(2);
    e = cyc + latency((2 + 1) % COLS, 0);
    wait_until(e - 1);
    chk("drop_early", 32'(kif.key_drop), 0);
    step();
    chk("drop_pulse", 32'(kif.key_drop), 1);
    chk("drop_code_kept", 32'(kif.key_code), 9);
    chk("drop_valid_kept", 32'(kif.key_valid), 1);
    step();
    chk("drop_width", 32'(kif.key_drop), 0);
    align();
    keys = '0;
    r = cyc + SCAN_DIV * DEBOUNCE;
    wait_until(r);
    chk("drop_rel2", 32'(kif.key_release), 1);
    k3 = $urandom_range(0, 15);
    keys = onehot(k3);
    e = cyc + latency(1, k3 / ROWS);
    wait_until(e - 1);
    kif.key_ready = 1'b1;
    step();
    kif.key_ready = 1'b0;
    chk("hs_accept_valid", 32'(kif.key_valid), 1);
    chk("hs_accept_code", 32'(kif.key_code), 32'(k3));
    chk("hs_accept_nodrop", 32'(kif.key_drop), 0);
    kif.key_ready = 1'b1;
    step();
    kif.key_ready = 1'b0;
    chk("hs_consumed", 32'(kif.key_valid), 0);
    keys = '0;

    // Reset in the middle of debounce.
    do_reset();
    c = $urandom_range(0, 3);
    k = c*ROWS + $urandom_range(0, 3);
    s = c + COLS;
    wait_until(SCAN_DIV * s);
    keys = onehot(k);
    wait_until(SCAN_DIV * s + 6);
    rst_n = 1'b0;
    keys = '0;
    repeat (3) step();
    chk("rdeb_col_n", 32'(col_n), 32'hF);
    chk("rdeb_valid", 32'(kif.key_valid), 0);
    chk("rdeb_release", 32'(kif.key_release), 0);
    rst_n = 1'b1;
    cyc = 0;
    step();
    chk("rdeb_col_first", 32'(col_n), 32'hE);
    quiet_window("rdeb");

    // Reset while a key is held with its code still pending.
    do_reset();
    c = $urandom_range(0, 3);
    k = c*ROWS + $urandom_range(0, 3);
    s = c + COLS;
    wait_until(SCAN_DIV * s);
    keys = onehot(k);
    wait_until(SCAN_DIV * s + latency(c, c));
    chk("rheld_valid", 32'(kif.key_valid), 1);
    repeat (2) step();
    rst_n = 1'b0;
    keys = '0;
    repeat (3) step();
    chk("rheld_rst_valid", 32'(kif.key_valid), 0);
    chk("rheld_rst_code", 32'(kif.key_code), 0);
    rst_n = 1'b1;
    cyc = 0;
    quiet_window("rheld");

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat: REPEAT_TICKS ticks of holding after the accept yields the same code again.
    do_reset();
    k = $urandom_range(0, 15);
    wait_until(SCAN_DIV);
    keys = onehot(k);
    e = cyc + latency(1, k / ROWS);
    wait_until(e);
    chk("rpt_first_valid", 32'(kif.key_valid), 1);
    kif.key_ready = 1'b1;
    step();
    kif.key_ready = 1'b0;
    chk("rpt_consumed", 32'(kif.key_valid), 0);
    wait_until(e + SCAN_DIV * REPEAT_TICKS - 1);
    chk("rpt_early", 32'(kif.key_valid), 0);
    step();
    chk("rpt_valid", 32'(kif.key_valid), 1);
    chk("rpt_code", 32'(kif.key_code), 32'(k));
    keys = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
